// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared types and constants for the UART receive buffer.
// Optional feature macro used by the RTL: UART_RX_OVERRUN_EN.
package uart_rx_fifo_pkg;

    // Receiver handshake states (1-bit encodings).
    typedef enum logic {
        RXF_IDLE = 1'b0,
        RXF_ACK  = 1'b1
    } rxf_state_t;

    localparam int RXF_DEPTH_DEFAULT = 16;
    localparam int RXF_DATA_W        = 8;

endpackage : uart_rx_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x 8 register array, one synchronous write port and
// one asynchronous (combinational) read port for first-word-fall-through use.
module sync_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int  DEPTH = RXF_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clock50,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [RXF_DATA_W-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [RXF_DATA_W-1:0] rd_data
);

    logic [RXF_DATA_W-1:0] mem [DEPTH];

    // Store the incoming byte at the tail slot.
    // NOTE: storage is deliberately not reset; occupancy is tracked by the
    // controller's count, so stale contents are never observed as valid data.
    always_ff @(posedge clock50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Head byte is visible without waiting for a clock edge.
    assign rd_data = mem[rd_addr];

endmodule : sync_fifo_mem

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from the UART receiver's sticky ready/data
// outputs, acknowledges each via rx_clear, and buffers them in a
// first-word-fall-through FIFO popped by the processor.
// Optional feature macro: UART_RX_OVERRUN_EN (sticky overrun flag + clear).
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int  DEPTH = RXF_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clock50,
    input  logic                  reset_n,
    input  logic                  rx_rdy,
    input  logic [RXF_DATA_W-1:0] rx_data,
    output logic                  rx_clear,
    input  logic                  rd_en,
    output logic [RXF_DATA_W-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
`ifdef UART_RX_OVERRUN_EN
    output logic                  overrun,
    input  logic                  ovr_clear,
`endif
    output logic [AW:0]           count
);

    rxf_state_t    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          capture;
    logic          do_pop;
    logic          wr_accept;

    // Occupancy flags come from the count so a full FIFO is never mistaken
    // for an empty one when the pointers coincide.
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A byte is taken only on the first cycle rx_rdy is seen in RXF_IDLE;
    // a write into a full FIFO still succeeds if a pop frees a slot this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        capture   = 1'b0;
        do_pop    = 1'b0;
        wr_accept = 1'b0;
        if (state == RXF_IDLE && rx_rdy) begin
            capture = 1'b1;
        end
        if (rd_en && !empty) begin
            do_pop = 1'b1;
        end
        if (capture && (!full || do_pop)) begin
            wr_accept = 1'b1;
        end
    end

    // Receiver handshake: raise rx_clear on capture, hold it until the
    // receiver has dropped its sticky ready flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RXF_IDLE;
            rx_clear <= 1'b0;
        end else begin
            case (state)
                RXF_IDLE: begin
                    if (rx_rdy) begin
                        rx_clear <= 1'b1;
                        state    <= RXF_ACK;
                    end
                end
                RXF_ACK: begin
                    if (!rx_rdy) begin
                        rx_clear <= 1'b0;
                        state    <= RXF_IDLE;
                    end
                end
                default: begin
                    rx_clear <= 1'b0;
                    state    <= RXF_IDLE;
                end
            endcase
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_accept, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef UART_RX_OVERRUN_EN
    logic drop;
    assign drop = capture && !wr_accept;

    // Sticky lost-byte flag; a drop in the same cycle as ovr_clear wins.
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clear) begin
            overrun <= 1'b0;
        end
    end
`endif

    sync_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock50 (clock50),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus for uart_rx_fifo (DEPTH=16) with a
// scoreboard queue of expected bytes and a monitor that checks every pop.
// Honors UART_RX_OVERRUN_EN to exercise the optional overrun flag.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clock50 = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_rdy  = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_clear;
    logic          rd_en   = 1'b0;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
`ifdef UART_RX_OVERRUN_EN
    logic          overrun;
    logic          ovr_clear = 1'b0;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    sb_q[$];

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clock50  (clock50),
        .reset_n  (reset_n),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .rx_clear (rx_clear),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
`ifdef UART_RX_OVERRUN_EN
        .overrun  (overrun),
        .ovr_clear(ovr_clear),
`endif
        .count    (count)
    );

    always #10 clock50 = ~clock50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock50);
        #1;
    endtask

    // Monitor: at each falling edge where a valid pop is presented, compare
    // the head byte against the oldest expected byte.
    always @(negedge clock50) begin
        if (reset_n && rd_en && !empty) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data);
            end else begin
                logic [7:0] exp_b;
                exp_b = sb_q.pop_front();
                if (rd_data !== exp_b) begin
                    errors++;
                    $display("FAIL pop_data: got 0x%0h expected 0x%0h", rd_data, exp_b);
                end
            end
        end
    end

    // Deliver one byte through the full receiver handshake.
    // accept: byte is expected to land in the FIFO; pop_same: pop in capture cycle.
    task automatic send_byte(input logic [7:0] b, input bit accept, input bit pop_same);
        rx_data = b;
        rx_rdy  = 1'b1;
        rd_en   = pop_same;
        if (accept) sb_q.push_back(b);
        tick();                                   // capture edge k
        rd_en = 1'b0;
        check("clr_after_k", {31'd0, rx_clear}, 32'd1);
        tick();                                   // edge k+1: receiver sees clear
        rx_rdy = 1'b0;
        check("clr_hold_k1", {31'd0, rx_clear}, 32'd1);
        tick();                                   // edge k+2: rdy seen low
        check("clr_fall_k2", {31'd0, rx_clear}, 32'd0);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #25;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full",  {31'd0, full},  32'd0);
        check("rst_count", 32'(count),     32'd0);
        check("rst_clear", {31'd0, rx_clear}, 32'd0);
`ifdef UART_RX_OVERRUN_EN
        check("rst_ovr", {31'd0, overrun}, 32'd0);
`endif
        @(posedge clock50); #1;
        reset_n = 1'b1;
        tick();

        // Single byte
        send_byte(8'hA5, 1'b1, 1'b0);
        check("single_empty", {31'd0, empty}, 32'd0);
        check("single_count", 32'(count),     32'd1);
        check("single_head",  32'(rd_data),   32'hA5);
        pop();
        check("single_pop_empty", {31'd0, empty}, 32'd1);
        check("single_pop_count", 32'(count),     32'd0);

        // Sticky ready held for 10 cycles: one capture only
        rx_data = 8'h3C;
        rx_rdy  = 1'b1;
        sb_q.push_back(8'h3C);
        for (int i = 0; i < 10; i++) tick();
        check("sticky_clear_hi", {31'd0, rx_clear}, 32'd1);
        check("sticky_count",    32'(count),        32'd1);
        rx_rdy = 1'b0;
        tick();
        check("sticky_clear_lo", {31'd0, rx_clear}, 32'd0);
        check("sticky_count2",   32'(count),        32'd1);
        pop();
        check("sticky_drained", 32'(count), 32'd0);

        // Fill and wrap
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1'b0);
        check("fill_full",  {31'd0, full}, 32'd1);
        check("fill_count", 32'(count),    32'd16);
        for (int i = 0; i < 4; i++) pop();
        check("pop4_count", 32'(count), 32'd12);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b1, 1'b0);
        check("wrap_full", {31'd0, full}, 32'd1);

        // Overrun: full FIFO drops the byte
        send_byte(8'h55, 1'b0, 1'b0);
        check("ovr_count", 32'(count), 32'd16);
`ifdef UART_RX_OVERRUN_EN
        check("ovr_set", {31'd0, overrun}, 32'd1);
        ovr_clear = 1'b1;
        tick();
        ovr_clear = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        // Drop coinciding with ovr_clear: set wins
        rx_data   = 8'h66;
        rx_rdy    = 1'b1;
        ovr_clear = 1'b1;
        tick();
        ovr_clear = 1'b0;
        check("ovr_set_wins", {31'd0, overrun}, 32'd1);
        tick();
        rx_rdy = 1'b0;
        tick();
        ovr_clear = 1'b1;
        tick();
        ovr_clear = 1'b0;
        check("ovr_cleared2", {31'd0, overrun}, 32'd0);
`endif

        // Simultaneous write and pop while full: 0x55 lands at the tail
        send_byte(8'h55, 1'b1, 1'b1);
        check("simul_count", 32'(count), 32'd16);
`ifdef UART_RX_OVERRUN_EN
        check("simul_no_ovr", {31'd0, overrun}, 32'd0);
`endif
        for (int i = 0; i < 20 && !empty; i++) pop();
        check("drain_count", 32'(count),     32'd0);
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_sb",    32'(sb_q.size()), 32'd0);

        // rd_en while empty is ignored
        pop();
        check("empty_pop_count", 32'(count),     32'd0);
        check("empty_pop_empty", {31'd0, empty}, 32'd1);

        // Async reset mid-handshake with count=3
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        rx_data = 8'h33;
        rx_rdy  = 1'b1;
        tick();
        check("pre_rst_count", 32'(count),        32'd3);
        check("pre_rst_clear", {31'd0, rx_clear}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_count", 32'(count),        32'd0);
        check("arst_empty", {31'd0, empty},    32'd1);
        check("arst_clear", {31'd0, rx_clear}, 32'd0);
        sb_q.delete();
        @(posedge clock50); #1;
        rx_data = 8'h77;
        sb_q.push_back(8'h77);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("recap_count", 32'(count), 32'd1);
        rx_rdy = 1'b0;
        tick();
        tick();
        check("recap_clear", {31'd0, rx_clear}, 32'd0);
        pop();
        check("recap_empty", {31'd0, empty},     32'd1);
        check("final_sb",    32'(sb_q.size()),   32'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo
